// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: base opcodes and instruction format codes.
package rv32i_pkg;

    localparam int ILEN = 32;

    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] MISC_MEM = 7'b0001111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_e;

endpackage

// File: rtl/rv32i_instruction_decoder_if.sv
// Fetch-to-decode bus: raw instruction in, registered decoded fields out.
interface rv32i_instruction_decoder_if;

    logic        valid_i;
    logic [31:0] machine_code;
    logic        valid_o;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        illegal;

    modport master (
        output valid_i, machine_code,
        input  valid_o, opcode, rd, funct3, rs1, rs2, funct7, imm, fmt, illegal
    );

    modport slave (
        input  valid_i, machine_code,
        output valid_o, opcode, rd, funct3, rs1, rs2, funct7, imm, fmt, illegal
    );

endinterface

// File: rtl/rv32i_imm_gen.sv
// Immediate generator: reassembles and sign-extends the immediate for a given format.
module rv32i_imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:7] instr,
    input  fmt_e        fmt,
    output logic [31:0] imm
);

    // Format-driven immediate assembly; sign always comes from instr[31].
    always_comb begin
        imm = 32'd0;
        case (fmt)
            FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm = {instr[31:12], 12'd0};
            FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/rv32i_instruction_decoder.sv
// RV32I decode stage: field extraction, format classification and immediate
// generation, registered for one cycle of latency.
module rv32i_instruction_decoder
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    rv32i_instruction_decoder_if.slave    bus
);

    logic [6:0]      opcode_s;
    fmt_e            fmt_s;
    logic            illegal_s;
    logic [XLEN-1:0] imm_s;

    logic            valid_r;
    logic [6:0]      opcode_r;
    logic [4:0]      rd_r;
    logic [2:0]      funct3_r;
    logic [4:0]      rs1_r;
    logic [4:0]      rs2_r;
    logic [6:0]      funct7_r;
    logic [XLEN-1:0] imm_r;
    fmt_e            fmt_r;
    logic            illegal_r;

    assign opcode_s = bus.machine_code[6:0];

    // Opcode to format classification; anything unrecognised is flagged illegal.
    always_comb begin
        fmt_s     = FMT_NONE;
        illegal_s = 1'b1;
        case (opcode_s)
            OP: begin
                fmt_s     = FMT_R;
                illegal_s = 1'b0;
            end
            LOAD, OP_IMM, JALR, MISC_MEM, SYSTEM: begin
                fmt_s     = FMT_I;
                illegal_s = 1'b0;
            end
            STORE: begin
                fmt_s     = FMT_S;
                illegal_s = 1'b0;
            end
            BRANCH: begin
                fmt_s     = FMT_B;
                illegal_s = 1'b0;
            end
            LUI, AUIPC: begin
                fmt_s     = FMT_U;
                illegal_s = 1'b0;
            end
            JAL: begin
                fmt_s     = FMT_J;
                illegal_s = 1'b0;
            end
            default: begin
                fmt_s     = FMT_NONE;
                illegal_s = 1'b1;
            end
        endcase
    end

    rv32i_imm_gen u_imm_gen (
        .instr (bus.machine_code[31:7]),
        .fmt   (fmt_s),
        .imm   (imm_s)
    );

    // Output registers: valid follows the input every cycle, payload loads only on valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r   <= 1'b0;
            opcode_r  <= 7'd0;
            rd_r      <= 5'd0;
            funct3_r  <= 3'd0;
            rs1_r     <= 5'd0;
            rs2_r     <= 5'd0;
            funct7_r  <= 7'd0;
            imm_r     <= '0;
            fmt_r     <= FMT_R;
            illegal_r <= 1'b0;
        end else begin
            valid_r <= bus.valid_i;
            if (bus.valid_i) begin
                opcode_r  <= opcode_s;
                rd_r      <= bus.machine_code[11:7];
                funct3_r  <= bus.machine_code[14:12];
                rs1_r     <= bus.machine_code[19:15];
                rs2_r     <= bus.machine_code[24:20];
                funct7_r  <= bus.machine_code[31:25];
                imm_r     <= imm_s;
                fmt_r     <= fmt_s;
                illegal_r <= illegal_s;
            end
        end
    end

    assign bus.valid_o = valid_r;
    assign bus.opcode  = opcode_r;
    assign bus.rd      = rd_r;
    assign bus.funct3  = funct3_r;
    assign bus.rs1     = rs1_r;
    assign bus.rs2     = rs2_r;
    assign bus.funct7  = funct7_r;
    assign bus.imm     = imm_r;
    assign bus.fmt     = fmt_r;
    assign bus.illegal = illegal_r;

endmodule

// File: tb/tb_rv32i_instruction_decoder.sv
// Scoreboard bench for rv32i_instruction_decoder: directed words with
// hand-computed format/immediate, checked by an independent negedge monitor.
module tb_rv32i_instruction_decoder;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] stamp;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic [31:0] cyc;
    exp_t sb[$];
    exp_t held;
    exp_t tab [0:10];

    rv32i_instruction_decoder_if bus ();

    rv32i_instruction_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 32'd1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void check_outputs(input string tag, input exp_t e);
        logic [31:0] w;
        w = e.word;
        chk({tag, "_opcode"},  {25'd0, bus.opcode},  {25'd0, w[6:0]});
        chk({tag, "_rd"},      {27'd0, bus.rd},      {27'd0, w[11:7]});
        chk({tag, "_funct3"},  {29'd0, bus.funct3},  {29'd0, w[14:12]});
        chk({tag, "_rs1"},     {27'd0, bus.rs1},     {27'd0, w[19:15]});
        chk({tag, "_rs2"},     {27'd0, bus.rs2},     {27'd0, w[24:20]});
        chk({tag, "_funct7"},  {25'd0, bus.funct7},  {25'd0, w[31:25]});
        chk({tag, "_imm"},     bus.imm,              e.imm);
        chk({tag, "_fmt"},     {29'd0, bus.fmt},     {29'd0, e.fmt});
        chk({tag, "_illegal"}, {31'd0, bus.illegal}, {31'd0, e.ill});
    endfunction

    // Monitor: pops an expectation per valid_o, otherwise checks the payload is held.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.valid_o) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid_o", {31'd0, bus.valid_o}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("latency", cyc, e.stamp + 32'd1);
                    check_outputs("dec", e);
                    held = e;
                end
            end else begin
                if (sb.size() != 0 && sb[0].stamp + 32'd1 == cyc)
                    chk("missing_valid_o", {31'd0, bus.valid_o}, 32'd1);
                check_outputs("hold", held);
            end
        end
    end

    task automatic drive(input logic v, input exp_t t);
        exp_t e;
        @(posedge clk);
        #1;
        bus.valid_i      = v;
        bus.machine_code = t.word;
        if (v) begin
            e       = t;
            e.stamp = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input logic [31:0] w);
        exp_t t;
        t      = '0;
        t.word = w;
        drive(1'b0, t);
    endtask

    initial begin
        exp_t z;
        exp_t t;
        n_checks = 0;
        n_errors = 0;
        cyc      = 32'd0;
        held     = '0;
        z        = '0;

        //              word          imm           fmt   ill   stamp
        tab[0]  = '{32'h001F71B3, 32'h00000000, 3'd0, 1'b0, 32'd0};  // R: rd=3 f3=7 rs1=30 rs2=1
        tab[1]  = '{32'h061F7193, 32'h00000061, 3'd1, 1'b0, 32'd0};  // OP-IMM
        tab[2]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 32'd0};  // addi x1,x0,-1
        tab[3]  = '{32'h001F71E7, 32'h00000001, 3'd1, 1'b0, 32'd0};  // JALR
        tab[4]  = '{32'h001F71A3, 32'h00000003, 3'd2, 1'b0, 32'd0};  // STORE
        tab[5]  = '{32'h001F71E3, 32'h00000802, 3'd3, 1'b0, 32'd0};  // BRANCH
        tab[6]  = '{32'h001F71EF, 32'h000F7800, 3'd5, 1'b0, 32'd0};  // JAL
        tab[7]  = '{32'h12345037, 32'h12345000, 3'd4, 1'b0, 32'd0};  // LUI
        tab[8]  = '{32'h0000007F, 32'h00000000, 3'd7, 1'b1, 32'd0};  // unknown opcode
        tab[9]  = '{32'h80000003, 32'hFFFFF800, 3'd1, 1'b0, 32'd0};  // LOAD, negative offset
        tab[10] = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 32'd0};  // BRANCH, negative offset

        rst_n            = 1'b0;
        bus.valid_i      = 1'b0;
        bus.machine_code = 32'd0;
        #3;
        chk("reset_valid_o", {31'd0, bus.valid_o}, 32'd0);
        check_outputs("reset", z);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Each word alone, followed by an idle cycle carrying a different word.
        for (int i = 0; i <= 10; i++) begin
            drive(1'b1, tab[i]);
            idle(32'hDEADBEEF ^ tab[i].word);
        end
        idle(32'h0000006F);

        // Back-to-back stream with no bubbles.
        for (int i = 0; i <= 10; i++)
            drive(1'b1, tab[10 - i]);
        idle(32'h00000013);
        idle(32'h00000013);

        // Asynchronous reset in mid-cycle with valid_i held high.
        t = tab[7];
        drive(1'b1, t);
        @(posedge clk);
        #1 chk("pre_reset_valid_o", {31'd0, bus.valid_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_valid_o", {31'd0, bus.valid_o}, 32'd0);
        check_outputs("async_reset", z);
        sb.delete();
        held = '0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        t.stamp = cyc;
        sb.push_back(t);
        idle(32'h00000000);
        drive(1'b1, tab[6]);
        idle(32'h00000000);

        for (int i = 0; i < 20 && sb.size() != 0; i++)
            @(posedge clk);
        @(negedge clk);
        if (sb.size() != 0)
            chk("drain_timeout", sb.size(), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
